// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: 4-word lines, write-back of dirty victims and fill from memory.
// Hit completes two cycles after acceptance. Optional hit/miss counters are enabled by `define CACHE_CTRL_STATS_EN.
module cache_ctrl #(
  parameter  int INDEX_W = 9,
  localparam int AW      = 7 + INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [0:AW-1]     cpu_addr,
  input  logic [0:15]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [0:15]       cpu_rdata,
  output logic              set_enable,
  output logic [0:INDEX_W-1] set_index,
  output logic [0:1]        set_word,
  output logic              set_cmp,
  output logic              set_write,
  output logic [0:4]        set_tag,
  output logic [0:15]       set_data_in,
  output logic              set_valid_in,
  input  logic              set_hit,
  input  logic              set_dirty,
  input  logic              set_valid,
  input  logic [0:4]        set_tag_out,
  input  logic [0:15]       set_data_out,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [0:AW-1]     mem_addr,
  output logic [0:15]       mem_wdata,
  input  logic [0:15]       mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [0:15]       hit_cnt,
  output logic [0:15]       miss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WBACK,
    S_FILL,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_wr;
  logic [0:AW-1]     r_addr;
  logic [0:15]       r_wdata;
  logic [0:4]        r_victim;
  logic [1:0]        r_cnt;
  logic [0:15]       r_rdata;

  logic [0:4]        w_tag;
  logic [0:INDEX_W-1] w_index;
  logic [0:1]        w_word;
  logic              w_hit;

  assign w_tag   = r_addr[0:4];
  assign w_index = r_addr[5:AW-3];
  assign w_word  = r_addr[AW-2:AW-1];
  assign w_hit   = set_hit & set_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_victim <= '0;
      r_cnt    <= 2'd0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_wr    <= cpu_wr;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_cnt <= 2'd0;
          if (w_hit) begin
            if (!r_wr) begin
              r_rdata <= set_data_out;
            end
            r_state <= S_DONE;
          end else if (set_valid && set_dirty) begin
            r_victim <= set_tag_out;
            r_state  <= S_WBACK;
          end else begin
            r_state <= S_FILL;
          end
        end
        S_WBACK: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_COMPARE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Set and memory strobes are decoded from state so that a fill beat can be
  // written into the set in the same cycle its mem_ack arrives.
  always_comb begin
    cpu_ready    = (r_state == S_IDLE);
    cpu_done     = (r_state == S_DONE);
    cpu_rdata    = r_rdata;
    set_enable   = 1'b0;
    set_index    = '0;
    set_word     = '0;
    set_cmp      = 1'b0;
    set_write    = 1'b0;
    set_tag      = '0;
    set_data_in  = '0;
    set_valid_in = 1'b0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      S_COMPARE: begin
        set_enable   = 1'b1;
        set_cmp      = 1'b1;
        set_write    = r_wr;
        set_tag      = w_tag;
        set_index    = w_index;
        set_word     = w_word;
        set_data_in  = r_wdata;
        set_valid_in = r_wr;
      end
      S_WBACK: begin
        set_enable = 1'b1;
        set_index  = w_index;
        set_word   = r_cnt;
        mem_req    = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = {r_victim, w_index, r_cnt};
        mem_wdata  = set_data_out;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_index, r_cnt};
        if (mem_ack) begin
          set_enable   = 1'b1;
          set_write    = 1'b1;
          set_valid_in = 1'b1;
          set_tag      = w_tag;
          set_index    = w_index;
          set_word     = r_cnt;
          set_data_in  = mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  logic        r_refill;
  logic [0:15] r_hit_cnt;
  logic [0:15] r_miss_cnt;

  // r_refill marks the re-compare after a fill so it is not counted twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refill   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == S_FILL && mem_ack && r_cnt == 2'd3) begin
        r_refill <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_refill <= 1'b0;
      end
      if (r_state == S_COMPARE && !r_refill) begin
        if (w_hit) begin
          if (r_hit_cnt != 16'hFFFF) begin
            r_hit_cnt <= r_hit_cnt + 16'd1;
          end
        end else begin
          if (r_miss_cnt != 16'hFFFF) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
          end
        end
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural set array and a memory with programmable ack delay.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_wr;
  logic [0:15] cpu_addr;
  logic [0:15] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [0:15] cpu_rdata;
  logic        set_enable;
  logic [0:8]  set_index;
  logic [0:1]  set_word;
  logic        set_cmp;
  logic        set_write;
  logic [0:4]  set_tag;
  logic [0:15] set_data_in;
  logic        set_valid_in;
  logic        set_hit;
  logic        set_dirty;
  logic        set_valid;
  logic [0:4]  set_tag_out;
  logic [0:15] set_data_out;
  logic        mem_req;
  logic        mem_wr;
  logic [0:15] mem_addr;
  logic [0:15] mem_wdata;
  logic [0:15] mem_rdata;
  logic        mem_ack;
`ifdef CACHE_CTRL_STATS_EN
  logic [0:15] hit_cnt;
  logic [0:15] miss_cnt;
`endif

  always #5 clk = ~clk;

  cache_ctrl #(.INDEX_W(9)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .set_enable(set_enable), .set_index(set_index), .set_word(set_word), .set_cmp(set_cmp),
    .set_write(set_write), .set_tag(set_tag), .set_data_in(set_data_in), .set_valid_in(set_valid_in),
    .set_hit(set_hit), .set_dirty(set_dirty), .set_valid(set_valid), .set_tag_out(set_tag_out),
    .set_data_out(set_data_out),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_CTRL_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Behavioural direct-mapped set array
  logic [511:0] m_valid = '0;
  logic [511:0] m_dirty = '0;
  logic [0:4]   m_tag  [0:511];
  logic [0:15]  m_data [0:511][0:3];
  int           n_fill = 0;
  logic         pl_en = 1'b0;
  logic [0:8]   pl_idx = '0;
  logic [0:4]   pl_tag = '0;
  logic [0:15]  pl_base = '0;

  assign set_valid    = m_valid[set_index];
  assign set_dirty    = m_dirty[set_index];
  assign set_tag_out  = m_tag[set_index];
  assign set_data_out = m_data[set_index][set_word];
  assign set_hit      = set_cmp && m_valid[set_index] && (m_tag[set_index] == set_tag);

  always @(posedge clk) begin
    if (pl_en) begin
      m_valid[pl_idx] <= 1'b1;
      m_dirty[pl_idx] <= 1'b1;
      m_tag[pl_idx]   <= pl_tag;
      for (int w = 0; w < 4; w++) m_data[pl_idx][w] <= pl_base + 16'(w);
    end else if (set_enable && set_write) begin
      if (set_cmp) begin
        if (set_hit) begin
          m_data[set_index][set_word] <= set_data_in;
          m_dirty[set_index]          <= 1'b1;
        end
      end else begin
        m_data[set_index][set_word] <= set_data_in;
        m_tag[set_index]            <= set_tag;
        m_valid[set_index]          <= set_valid_in;
        m_dirty[set_index]          <= 1'b0;
        n_fill                      <= n_fill + 1;
      end
    end
  end

  // Memory responder: acks each beat after ack_delay idle cycles and logs it.
  int          ack_delay = 0;
  int          n_beats = 0;
  int          stable_err = 0;
  int          wait_cnt = 0;
  logic        log_wr    [0:255];
  logic [0:15] log_addr  [0:255];
  logic [0:15] log_wdata [0:255];
  logic [0:15] beat_addr;
  logic [0:15] beat_wdata;

  function automatic logic [0:15] mem_val(input logic [0:15] a);
    mem_val = a ^ 16'h5A5A;
  endfunction

  function automatic logic [0:15] mk(input logic [0:4] t, input int i, input int w);
    logic [8:0] iv;
    logic [1:0] wv;
    iv = i[8:0];
    wv = w[1:0];
    mk = {t, iv, wv};
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !rst) begin
        if (wait_cnt == 0) begin
          beat_addr  = mem_addr;
          beat_wdata = mem_wdata;
        end else if (mem_addr != beat_addr || mem_wr != log_wr[n_beats & 255] && 1'b0) begin
          stable_err++;
        end
        if (mem_wr && mem_wdata != beat_wdata) stable_err++;
        if (wait_cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val(mem_addr);
          log_wr[n_beats & 255]    = mem_wr;
          log_addr[n_beats & 255]  = mem_addr;
          log_wdata[n_beats & 255] = mem_wdata;
          n_beats++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic        snap_en, snap_cmp, snap_wr, snap_rdy;
  logic [0:15] snap_din;

  task automatic do_req(input logic wr, input logic [0:15] addr, input logic [0:15] wd,
                        input bit inject, output int cyc);
    int  guard;
    bit  seen;
    guard = 0;
    while (!cpu_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    cyc = 0;
    seen = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        snap_en = set_enable; snap_cmp = set_cmp; snap_wr = set_write;
        snap_din = set_data_in; snap_rdy = cpu_ready;
      end
      if (cpu_done) begin
        seen = 1;
        break;
      end
      if (inject && (cyc % 3 == 0)) begin
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = mk(5'b00111, 21, 0); cpu_wdata = 16'hDEAD;
      end else begin
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  int cyc, b0, f0, guard;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_set_en", 32'(set_enable), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold read, idx 3 word 3
    b0 = n_beats; f0 = n_fill;
    do_req(1'b0, mk(5'b11101, 3, 3), 16'h0, 0, cyc);
    check("cold_cycles", 32'(cyc), 32'd7);
    check("cold_beats", 32'(n_beats - b0), 32'd4);
    check("cold_fills", 32'(n_fill - f0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("cold_rd", 32'(log_wr[b0 + k]), 32'd0);
      check("cold_addr", 32'(log_addr[b0 + k]), 32'(mk(5'b11101, 3, k)));
      check("cold_line", 32'(m_data[3][k]), 32'(mem_val(mk(5'b11101, 3, k))));
    end
    check("cold_rdata", 32'(cpu_rdata), 32'(mem_val(mk(5'b11101, 3, 3))));

    // Write hit
    b0 = n_beats;
    do_req(1'b1, mk(5'b11101, 3, 1), 16'h0F0F, 0, cyc);
    check("wr_cycles", 32'(cyc), 32'd2);
    check("wr_cmp_en", 32'({snap_en, snap_cmp, snap_wr}), 32'h7);
    check("wr_cmp_din", 32'(snap_din), 32'h0F0F);
    check("wr_busy_ready", 32'(snap_rdy), 32'd0);
    check("wr_no_mem", 32'(n_beats - b0), 32'd0);
    check("wr_rdata_hold", 32'(cpu_rdata), 32'(mem_val(mk(5'b11101, 3, 3))));
    @(negedge clk);
    check("wr_set_data", 32'(m_data[3][1]), 32'h0F0F);
    check("wr_dirty", 32'(m_dirty[3]), 32'd1);

    // Read hit returns the written word
    do_req(1'b0, mk(5'b11101, 3, 1), 16'h0, 0, cyc);
    check("rdhit_cycles", 32'(cyc), 32'd2);
    check("rdhit_rdata", 32'(cpu_rdata), 32'h0F0F);

    // Dirty miss with victim tag 00001 at idx 7
    pl_idx = 9'd7; pl_tag = 5'b00001; pl_base = 16'h1110; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
    b0 = n_beats;
    do_req(1'b0, mk(5'b10010, 7, 2), 16'h0, 0, cyc);
    check("wb_cycles", 32'(cyc), 32'd11);
    check("wb_beats", 32'(n_beats - b0), 32'd8);
    for (int k = 0; k < 4; k++) begin
      check("wb_wr", 32'(log_wr[b0 + k]), 32'd1);
      check("wb_addr", 32'(log_addr[b0 + k]), 32'(mk(5'b00001, 7, k)));
      check("wb_wdata", 32'(log_wdata[b0 + k]), 32'h1110 + 32'(k));
      check("wb_fill_rd", 32'(log_wr[b0 + 4 + k]), 32'd0);
      check("wb_fill_addr", 32'(log_addr[b0 + 4 + k]), 32'(mk(5'b10010, 7, k)));
    end
    check("wb_rdata", 32'(cpu_rdata), 32'(mem_val(mk(5'b10010, 7, 2))));
    check("wb_new_tag", 32'(m_tag[7]), 32'(5'b10010));
    check("wb_clean", 32'(m_dirty[7]), 32'd0);

    // Slow memory with ignored CPU pulses
    ack_delay = 3; b0 = n_beats; stable_err = 0;
    do_req(1'b0, mk(5'b01010, 20, 0), 16'h0, 1, cyc);
    check("slow_cycles", 32'(cyc), 32'd19);
    check("slow_beats", 32'(n_beats - b0), 32'd4);
    check("slow_stable", 32'(stable_err), 32'd0);
    check("slow_rdata", 32'(cpu_rdata), 32'(mem_val(mk(5'b01010, 20, 0))));
    check("slow_no_queue", 32'(m_valid[21]), 32'd0);
    repeat (4) @(negedge clk);
    check("slow_idle", 32'(cpu_ready), 32'd1);

    // Reset during FILL beat 2
    ack_delay = 2; b0 = n_beats; f0 = n_fill;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = mk(5'b00110, 30, 0);
    @(negedge clk);
    cpu_req = 1'b0;
    guard = 0;
    while (n_beats - b0 < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rstf_reach", 32'(guard < 200), 32'd1);
    @(negedge clk);
    check("rstf_pre_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstf_mem_req", 32'(mem_req), 32'd0);
    check("rstf_mem_addr", 32'(mem_addr), 32'd0);
    check("rstf_set_en", 32'({set_enable, set_write, set_valid_in}), 32'd0);
    check("rstf_set_bus", 32'({set_tag, set_data_in, set_index}), 32'd0);
    check("rstf_rdata", 32'({cpu_rdata, cpu_done}), 32'd0);
    check("rstf_idle", 32'(cpu_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("rstf_fills", 32'(n_fill - f0), 32'd2);
    rst = 1'b0;
    ack_delay = 0;
    @(negedge clk);

    // Recovery: miss then hit on a fresh line
    do_req(1'b0, mk(5'b10101, 40, 1), 16'h0, 0, cyc);
    check("rec_cycles", 32'(cyc), 32'd7);
    check("rec_rdata", 32'(cpu_rdata), 32'(mem_val(mk(5'b10101, 40, 1))));
    do_req(1'b0, mk(5'b10101, 40, 2), 16'h0, 0, cyc);
    check("rec_hit_cycles", 32'(cyc), 32'd2);
    check("rec_hit_rdata", 32'(cpu_rdata), 32'(mem_val(mk(5'b10101, 40, 2))));
`ifdef CACHE_CTRL_STATS_EN
    check("stats_hit", 32'(hit_cnt), 32'd1);
    check("stats_miss", 32'(miss_cnt), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
